// File: rtl/buffer_reader.sv
// Drain side of the four-queue packet buffer: round-robin pick of each buffer's head
// entry, valid/ready presentation, then a clear command back to the capture stage.
module buffer_reader #(
   parameter int unsigned NUM_SLOTS   = 6,
   parameter int unsigned CLR_TIMEOUT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [3*NUM_SLOTS-1:0] buffer1_i,
   input  logic [3*NUM_SLOTS-1:0] buffer2_i,
   input  logic [3*NUM_SLOTS-1:0] buffer3_i,
   input  logic [3*NUM_SLOTS-1:0] buffer4_i,
   input  logic                   pkt_ready,
   output logic                   pkt_valid,
   output logic [1:0]             pkt_buf,
   output logic [1:0]             pkt_data,
   output logic                   clr_en,
   output logic [1:0]             clr_buf,
   output logic [2:0]             clr_slot,
   output logic                   busy,
   output logic                   err
);

   localparam int unsigned NUM_BUFS  = 4;
   localparam int unsigned BUF_IDX_W = 2;
   localparam int unsigned SLOT_W    = 3;
   localparam int unsigned BUF_W     = SLOT_W * NUM_SLOTS;
   localparam int unsigned PTR_W     = 3;
   localparam int unsigned CNT_W     = $clog2(CLR_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESENT  = 2'd1,
      CLEAR    = 2'd2,
      WAIT_CLR = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [PTR_W-1:0]       rd_ptr_q [NUM_BUFS];
   logic [PTR_W-1:0]       rd_ptr_d [NUM_BUFS];
   logic [BUF_IDX_W-1:0]   rr_q, rr_d;
   logic [BUF_IDX_W-1:0]   g_q, g_d;
   logic [PTR_W-1:0]       s_q, s_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic                   pkt_valid_d;
   logic [1:0]             pkt_buf_d;
   logic [1:0]             pkt_data_d;
   logic                   clr_en_d;
   logic [1:0]             clr_buf_d;
   logic [2:0]             clr_slot_d;
   logic                   busy_d;
   logic                   err_d;

   logic [BUF_W-1:0]       bufs [NUM_BUFS];
   logic [SLOT_W-1:0]      head_slot [NUM_BUFS];
   logic [NUM_BUFS-1:0]    req;
   logic                   win_found;
   logic [BUF_IDX_W-1:0]   win;
   logic [SLOT_W-1:0]      win_slot;
   logic [SLOT_W-1:0]      cur_slot;
   logic                   advance;
   logic [PTR_W-1:0]       next_ptr;

   assign bufs[0] = buffer1_i;
   assign bufs[1] = buffer2_i;
   assign bufs[2] = buffer3_i;
   assign bufs[3] = buffer4_i;

   // Select slot s ({data, valid}) out of a packed buffer view.
   function automatic logic [SLOT_W-1:0] slot_of(input logic [BUF_W-1:0] v,
                                                 input logic [PTR_W-1:0] s);
      logic [SLOT_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (s == PTR_W'(i)) r = v[SLOT_W*i +: SLOT_W];
      end
      return r;
   endfunction

   // Only the head slot of each buffer can request.
   always_comb begin
      req = '0;
      for (int unsigned b = 0; b < NUM_BUFS; b++) begin
         head_slot[b] = slot_of(bufs[b], rd_ptr_q[b]);
         req[b]       = head_slot[b][0];
      end
   end

   // Round-robin search starting just after the last granted buffer.
   always_comb begin
      logic [BUF_IDX_W-1:0] cand;
      cand      = '0;
      win_found = 1'b0;
      win       = rr_q;
      for (int unsigned k = 1; k <= NUM_BUFS; k++) begin
         cand = rr_q + BUF_IDX_W'(k);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win       = cand;
         end
      end
   end

   assign win_slot = head_slot[win];
   assign cur_slot = slot_of(bufs[g_q], s_q);
   assign next_ptr = (rd_ptr_q[g_q] == PTR_W'(NUM_SLOTS - 1)) ? '0
                                                              : rd_ptr_q[g_q] + PTR_W'(1);

   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      rr_d        = rr_q;
      g_d         = g_q;
      s_d         = s_q;
      cnt_d       = cnt_q;
      pkt_valid_d = pkt_valid;
      pkt_buf_d   = pkt_buf;
      pkt_data_d  = pkt_data;
      clr_en_d    = 1'b0;
      clr_buf_d   = clr_buf;
      clr_slot_d  = clr_slot;
      err_d       = err;
      advance     = 1'b0;

      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d     = PRESENT;
               g_d         = win;
               s_d         = rd_ptr_q[win];
               pkt_valid_d = 1'b1;
               pkt_buf_d   = win;
               pkt_data_d  = win_slot[2:1];
            end
         end
         PRESENT: begin
            if (pkt_ready) begin
               state_d     = CLEAR;
               pkt_valid_d = 1'b0;
               clr_en_d    = 1'b1;
               clr_buf_d   = g_q;
               clr_slot_d  = s_q;
            end
         end
         CLEAR: begin
            state_d = WAIT_CLR;
            cnt_d   = '0;
         end
         WAIT_CLR: begin
            if (!cur_slot[0]) begin
               advance = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               // Give up on a clear that never lands, but keep the queue moving.
               if (cnt_q == CNT_W'(CLR_TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  advance = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (advance) begin
         rd_ptr_d[g_q] = next_ptr;
         rr_d          = g_q;
         state_d       = IDLE;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         for (int unsigned b = 0; b < NUM_BUFS; b++) rd_ptr_q[b] <= '0;
         rr_q      <= BUF_IDX_W'(NUM_BUFS - 1);
         g_q       <= '0;
         s_q       <= '0;
         cnt_q     <= '0;
         pkt_valid <= 1'b0;
         pkt_buf   <= '0;
         pkt_data  <= '0;
         clr_en    <= 1'b0;
         clr_buf   <= '0;
         clr_slot  <= '0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_ptr_q  <= rd_ptr_d;
         rr_q      <= rr_d;
         g_q       <= g_d;
         s_q       <= s_d;
         cnt_q     <= cnt_d;
         pkt_valid <= pkt_valid_d;
         pkt_buf   <= pkt_buf_d;
         pkt_data  <= pkt_data_d;
         clr_en    <= clr_en_d;
         clr_buf   <= clr_buf_d;
         clr_slot  <= clr_slot_d;
         busy      <= busy_d;
         err       <= err_d;
      end
   end

   // Output-port protocol properties.
   a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (pkt_valid && !pkt_ready) |=> (pkt_valid && $stable(pkt_buf) && $stable(pkt_data)));
   a_clr_pulse: assert property (@(posedge clk) disable iff (!rst_n)
      clr_en |=> !clr_en);
   a_valid_busy: assert property (@(posedge clk) disable iff (!rst_n)
      pkt_valid |-> busy);

endmodule

// File: doc/buffer_reader.md
# buffer_reader

Drain side of the four-queue packet buffer. It watches the four packed 18-bit buffer views produced by the input-capture stage. Each view holds six 3-bit slots of {data[1:0], valid}. The block picks pending entries in per-buffer FIFO order, with round-robin arbitration across buffers. It presents each entry on a valid/ready output port, then commands the capture stage to clear that slot's valid bit.

## Interface
- NUM_SLOTS, 6, slots per buffer; read pointers wrap NUM_SLOTS-1 -> 0
- CLR_TIMEOUT, 4, cycles to wait for a cleared valid bit before flagging an error
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- buffer1_i .. buffer4_i  in  18 each  packed slot views; slot s = bits [3s+2:3s]: [3s+2:3s+1] data, [3s] valid
- pkt_ready  in  1  downstream accepts the packet this cycle
- pkt_valid  out  1  packet available
- pkt_buf  out  2  source buffer index (0 = buffer1 .. 3 = buffer4)
- pkt_data  out  2  packet payload
- clr_en  out  1  one-cycle pulse: capture stage clears the valid bit of (clr_buf, clr_slot)
- clr_buf  out  2  buffer index to clear
- clr_slot  out  3  slot index to clear (0..5)
- busy  out  1  high in any state except IDLE
- err  out  1  sticky clear-timeout flag

## Operation
- State per buffer b: rd_ptr[b] (3 bits, 0..5). Request req[b] = valid bit of slot rd_ptr[b] in buffer b.
- Round-robin pointer rr (2 bits) holds the last granted buffer. Search order is rr+1, rr+2, rr+3, rr (mod 4). The first requester in that order wins.
- FSM states:
  - IDLE: if any req, latch g = winner, pkt_buf = g, pkt_data = data bits of that slot, and slot index s = rd_ptr[g]; go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: pkt_valid = 1. pkt_buf and pkt_data hold stable regardless of input changes. Transfer occurs on a cycle with pkt_valid and pkt_ready both high; then go to CLEAR. With no ready, wait indefinitely.
  - CLEAR: clr_en = 1 for exactly this cycle, with clr_buf = g and clr_slot = s. Zero the timeout counter. Go to WAIT_CLR.
  - WAIT_CLR: each cycle, sample the valid bit of (g, s).
    - If it is 0: rd_ptr[g] advances (5 wraps to 0), rr = g, go to IDLE.
    - Otherwise the counter increments. When the counter reaches CLR_TIMEOUT: set err = 1, advance rd_ptr[g], set rr = g, go to IDLE.
- A valid bit sampled at a slot other than rd_ptr[b] is ignored; only the head slot of each buffer is eligible.
- When the writer's pointer has wrapped and overwritten unread slots, the reader still proceeds in slot order. Loss detection is out of scope.
- err clears only on reset.

## Timing
- Reset values (asserted asynchronously): state = IDLE, all rd_ptr = 0, rr = 3 (so buffer1 wins first), pkt_valid = 0, pkt_buf = 0, pkt_data = 0, clr_en = 0, clr_buf = 0, clr_slot = 0, busy = 0, err = 0, counter = 0.
- Latency: a req high at edge n (while in IDLE) gives pkt_valid = 1 after edge n, i.e. one cycle later.
- With pkt_ready tied high and an immediate clear, each packet takes 4 cycles: IDLE, PRESENT, CLEAR, WAIT_CLR.
- All outputs are registered. No combinational path exists from inputs to outputs.
- Simultaneous requests from all four buffers after reset are granted in order 0, 1, 2, 3, 0, ...
- Reset asserted mid-transfer (any state) drops pkt_valid and clr_en immediately and loses no pointer consistency: all read pointers return to 0, matching a reset capture stage.

## Test plan
- Single entry: set buffer1_i slot0 = {2'b10, 1}, pkt_ready = 1, model the clear. Required: pkt_valid one cycle later with pkt_buf = 0 and pkt_data = 2'b10; clr_en pulse with clr_buf = 0 and clr_slot = 0; rd_ptr[0] = 1; idle afterwards.
- Round-robin: slot0 valid in all four buffers with distinct data. Required: grant order 0, 1, 2, 3, each packet 4 cycles apart, and clr_buf matching each grant.
- Backpressure: hold pkt_ready = 0 for 5 cycles while the input slot data changes. Required: pkt_valid stays high, pkt_data is unchanged, and exactly one clr_en follows the first ready.
- Wrap: push 7 entries into buffer3 sequentially. Required: clr_slot sequence 0, 1, 2, 3, 4, 5, 0, and payloads delivered in order.
- Clear timeout: the bench ignores clr_en for buffer2. Required: err = 1 exactly CLR_TIMEOUT cycles after WAIT_CLR entry, rd_ptr[1] advances, and the next requester is still serviced.
- Mid-operation reset: pull rst_n low during PRESENT. Required: all outputs at their reset values immediately; after release with buffers unchanged, the entry at slot 0 is presented again.
